// File: rtl/lsu_cmd_dispatch.sv
// lsu_cmd_dispatch: per-LSU command FIFOs with start/done sequencing of two LSUs
// Ports: cmd_* command input (valid/ready, cmd_lsu selects target FIFO);
//   lsuN_desc/lsuN_start/lsuN_done LSU handshakes; pending0/1 queued+in-flight counts;
//   done_cnt wrapping completion count; idle global idle; err sticky {timeout, unexpected done};
//   err_clr clears err. Optional watchdog: define LSU_DISPATCH_TIMEOUT_EN.
module lsu_cmd_dispatch #(
  parameter int CMD_W          = 192,
  parameter int QDEPTH         = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [CMD_W-1:0]           cmd_data,
  input  logic                       cmd_lsu,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  output logic [CMD_W-1:0]           lsu0_desc,
  output logic                       lsu0_start,
  input  logic                       lsu0_done,
  output logic [CMD_W-1:0]           lsu1_desc,
  output logic                       lsu1_start,
  input  logic                       lsu1_done,
  output logic [$clog2(QDEPTH)+1:0]  pending0,
  output logic [$clog2(QDEPTH)+1:0]  pending1,
  output logic [CNT_W-1:0]           done_cnt,
  output logic                       idle,
  output logic [1:0]                 err,
  input  logic                       err_clr
);
  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 2;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_e;
  logic [1:0] done_v, full_v, empty_v, idle_v, start_v, done_ok, unexp, tmo;
  logic [CMD_W-1:0] desc_a [2];
  logic [PW-1:0] pend_a [2];
  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("lsu_cmd_dispatch: QDEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
  end
  assign done_v = {lsu1_done, lsu0_done};
  // Ready looks only at the pre-pop full flag, so a same-cycle pop never frees a slot early.
  assign cmd_ready = !full_v[cmd_lsu];
  for (genvar g = 0; g < 2; g++) begin : g_lsu
    logic [AW:0] wp_q, rp_q;
    logic [CMD_W-1:0] mem_q [QDEPTH];
    logic [CMD_W-1:0] desc_q;
    state_e st_q, st_d;
    logic empty, push, adv, pop, t;
    assign empty = wp_q == rp_q;
    // Full when the pointers differ only in the wrap bit.
    assign full_v[g] = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
    assign push = cmd_valid && cmd_ready && (cmd_lsu == 1'(g));
    // adv: the FSM may take the next command (idle, or busy command finished/aborted).
    always_comb begin
      adv = st_q == S_IDLE || (st_q == S_BUSY && (done_v[g] || t));
      pop = adv && !empty;
      st_d = st_q == S_ISSUE ? S_BUSY : pop ? S_ISSUE : adv ? S_IDLE : st_q;
    end
    always_ff @(posedge clk)
      if (push) mem_q[wp_q[AW-1:0]] <= cmd_data;
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        wp_q   <= '0;
        rp_q   <= '0;
        st_q   <= S_IDLE;
        desc_q <= '0;
      end else begin
        wp_q <= wp_q + {{AW{1'b0}}, push};
        rp_q <= rp_q + {{AW{1'b0}}, pop};
        st_q <= st_d;
        if (pop) desc_q <= mem_q[rp_q[AW-1:0]];
      end
`ifdef LSU_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] wd_q;
    // Counter is 0 on the first BUSY cycle, so the abort lands TIMEOUT_CYCLES-1 cycles into BUSY.
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) wd_q <= '0;
      else wd_q <= st_q == S_BUSY ? wd_q + 1'b1 : '0;
    assign t = st_q == S_BUSY && !done_v[g] && wd_q == TW'(TIMEOUT_CYCLES - 1);
`else
    assign t = 1'b0;
`endif
    assign empty_v[g] = empty;
    assign idle_v[g]  = st_q == S_IDLE;
    assign start_v[g] = st_q == S_ISSUE;
    assign done_ok[g] = st_q == S_BUSY && done_v[g];
    assign unexp[g]   = done_v[g] && st_q != S_BUSY;
    assign tmo[g]     = t;
    assign desc_a[g]  = desc_q;
    assign pend_a[g]  = {1'b0, wp_q - rp_q} + {{(AW+1){1'b0}}, st_q != S_IDLE};
  end
  assign lsu0_desc  = desc_a[0];
  assign lsu1_desc  = desc_a[1];
  assign lsu0_start = start_v[0];
  assign lsu1_start = start_v[1];
  assign pending0   = pend_a[0];
  assign pending1   = pend_a[1];
  assign idle       = &empty_v && &idle_v && !cmd_valid;
  // Error set has priority over err_clr.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      done_cnt <= '0;
      err      <= '0;
    end else begin
      done_cnt <= done_cnt + CNT_W'(done_ok[0]) + CNT_W'(done_ok[1]);
      err      <= {|tmo || (!err_clr && err[1]), |unexp || (!err_clr && err[0])};
    end
endmodule
